// File: rtl/input_port_controller.sv
// input_port_controller
// Input side of the processor's IN port together with its interrupt line.
// Words arrive from an external device over a valid/ready handshake, wait in
// a small circular FIFO, and the head word is shown on input_port until the
// processor's IN strobe (in_read) pops it. A three-state FSM
// (IDLE/PULSE/SERVICE) raises interrupt_signal for INT_HOLD cycles while data
// is waiting. It does not raise it again until the processor has taken a word.
//
// Ports:
//   clk              - sole clock, rising edge
//   rst              - asynchronous active-low reset
//   dev_valid        - device offers dev_data
//   dev_data         - device word
//   dev_ready        - FIFO not full
//   in_read          - processor IN strobe, pops the head word
//   int_enable       - gates interrupt generation
//   input_port       - head word, 0 when empty
//   in_valid         - FIFO non-empty
//   interrupt_signal - registered interrupt request (state == PULSE)
//   count            - current occupancy
//   underflow        - one-cycle pulse after an in_read while empty
module input_port_controller #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int INT_HOLD   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dev_valid,
  input  logic [DATA_WIDTH-1:0]   dev_data,
  output logic                    dev_ready,
  input  logic                    in_read,
  input  logic                    int_enable,
  output logic [DATA_WIDTH-1:0]   input_port,
  output logic                    in_valid,
  output logic                    interrupt_signal,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = $clog2(INT_HOLD) + 1;

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(INT_HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PULSE   = 2'b01,
    ST_SERVICE = 2'b10
  } state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  underflow_q, underflow_d;
  state_e                state_q, state_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic                  popped_q, popped_d;
  logic                  int_q, int_d;
  logic                  push_s, pop_s;

  assign dev_ready        = (count_q != CNT_FULL);
  assign in_valid         = (count_q != {CW{1'b0}});
  assign input_port       = in_valid ? mem_q[rd_ptr_q] : {DATA_WIDTH{1'b0}};
  assign count            = count_q;
  assign underflow        = underflow_q;
  assign interrupt_signal = int_q;

  // FIFO pointer, occupancy and underflow next-state
  always_comb begin
    push_s      = dev_valid && dev_ready;
    pop_s       = in_read && in_valid;
    underflow_d = in_read && !in_valid;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Interrupt FSM next-state; popped_d remembers a pop seen during PULSE
  // so SERVICE can leave on its very first cycle.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    popped_d = popped_q;
    case (state_q)
      ST_IDLE: begin
        popped_d = 1'b0;
        if (int_enable && in_valid) begin
          state_d = ST_PULSE;
          hold_d  = HOLD_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PULSE: begin
        popped_d = popped_q || pop_s;
        if (!int_enable) begin
          state_d  = ST_IDLE;
          popped_d = 1'b0;
        end else if (hold_q == {HW{1'b0}}) begin
          state_d = ST_SERVICE;
        end else begin
          hold_d = hold_q - HOLD_ONE;
        end
      end
      ST_SERVICE: begin
        if (!int_enable || pop_s || popped_q) begin
          state_d  = ST_IDLE;
          popped_d = 1'b0;
        end else begin
          state_d = ST_SERVICE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        hold_d   = {HW{1'b0}};
        popped_d = 1'b0;
      end
    endcase
    int_d = (state_d == ST_PULSE);
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      underflow_q <= 1'b0;
      state_q     <= ST_IDLE;
      hold_q      <= {HW{1'b0}};
      popped_q    <= 1'b0;
      int_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      popped_q    <= popped_d;
      int_q       <= int_d;
    end
  end

  // FIFO storage; contents are never visible while empty, so no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= dev_data;
    end
  end

endmodule

// File: tb/tb_input_port_controller.sv
module tb_input_port_controller;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        dev_valid;
  logic [15:0] dev_data;
  logic        dev_ready;
  logic        in_read;
  logic        int_enable;
  logic [15:0] input_port;
  logic        in_valid;
  logic        interrupt_signal;
  logic [2:0]  count;
  logic        underflow;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  bit          exp_uf;

  input_port_controller dut (
    .clk(clk), .rst(rst), .dev_valid(dev_valid), .dev_data(dev_data),
    .dev_ready(dev_ready), .in_read(in_read), .int_enable(int_enable),
    .input_port(input_port), .in_valid(in_valid),
    .interrupt_signal(interrupt_signal), .count(count), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Updates the scoreboard for the coming edge, then advances one cycle.
  task automatic tick();
    bit acc_push, acc_pop;
    acc_push = dev_valid && (exp_q.size() < DEPTH);
    acc_pop  = in_read && (exp_q.size() != 0);
    exp_uf   = in_read && (exp_q.size() == 0);
    if (acc_pop) void'(exp_q.pop_front());
    if (acc_push) exp_q.push_back(dev_data);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; dev_valid = 1'b0; dev_data = 16'h0000; in_read = 1'b0; int_enable = 1'b0;
    #12;
    n_checks++; if (interrupt_signal !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %b expected 0", interrupt_signal); end
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL reset_uf: got %b expected 0", underflow); end
    n_checks++; if (in_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", in_valid); end
    n_checks++; if (input_port !== 16'h0000) begin n_fail++; $display("FAIL reset_port: got %h expected 0000", input_port); end
    n_checks++; if (dev_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", dev_ready); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_order();
    logic [15:0] words [3];
    bit int_seen;
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
    int_seen = 1'b0;
    dev_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dev_data = words[i];
      tick();
      int_seen = int_seen | interrupt_signal;
    end
    dev_valid = 1'b0;
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL order_count: got %0d expected 3", count); end
    n_checks++; if (input_port !== 16'h1111) begin n_fail++; $display("FAIL order_head: got %h expected 1111", input_port); end
    in_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (input_port !== exp_q[0]) begin n_fail++; $display("FAIL order_pop%0d: got %h expected %h", i, input_port, exp_q[0]); end
      tick();
      int_seen = int_seen | interrupt_signal;
    end
    in_read = 1'b0;
    n_checks++; if (input_port !== 16'h0000) begin n_fail++; $display("FAIL order_empty_port: got %h expected 0000", input_port); end
    n_checks++; if (in_valid !== 1'b0) begin n_fail++; $display("FAIL order_empty_valid: got %b expected 0", in_valid); end
    n_checks++; if (int_seen !== 1'b0) begin n_fail++; $display("FAIL order_no_int: got %b expected 0", int_seen); end
  endtask

  task automatic test_full_wrap();
    dev_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dev_data = 16'hA000 + 16'(i);
      tick();
    end
    dev_data = 16'hA004;
    n_checks++; if (dev_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", dev_ready); end
    tick();
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_hold_count: got %0d expected 4", count); end
    in_read = 1'b1;
    n_checks++; if (input_port !== exp_q[0]) begin n_fail++; $display("FAIL full_pop: got %h expected %h", input_port, exp_q[0]); end
    tick();
    in_read = 1'b0;
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_pop_count: got %0d expected 3", count); end
    tick();
    dev_valid = 1'b0;
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_fifth_count: got %0d expected 4", count); end
    in_read = 1'b1;
    n_checks++; if (input_port !== exp_q[0]) begin n_fail++; $display("FAIL wrap_pop_pre: got %h expected %h", input_port, exp_q[0]); end
    tick();
    dev_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dev_data = 16'hB000 + 16'(i);
      n_checks++; if (input_port !== exp_q[0]) begin n_fail++; $display("FAIL wrap_pair%0d: got %h expected %h", i, input_port, exp_q[0]); end
      tick();
      n_checks++; if (count !== 3'(exp_q.size())) begin n_fail++; $display("FAIL wrap_count%0d: got %0d expected %0d", i, count, exp_q.size()); end
    end
    dev_valid = 1'b0;
    while (exp_q.size() != 0) begin
      n_checks++; if (input_port !== exp_q[0]) begin n_fail++; $display("FAIL wrap_drain: got %h expected %h", input_port, exp_q[0]); end
      tick();
    end
    in_read = 1'b0;
  endtask

  task automatic test_interrupt();
    int_enable = 1'b1; dev_valid = 1'b1; dev_data = 16'hABCD;
    tick();
    dev_valid = 1'b0;
    n_checks++; if (interrupt_signal !== 1'b0) begin n_fail++; $display("FAIL irq_n0: got %b expected 0", interrupt_signal); end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++; if (interrupt_signal !== (k < 2)) begin n_fail++; $display("FAIL irq_n%0d: got %b expected %b", k + 1, interrupt_signal, (k < 2)); end
    end
    in_read = 1'b1;
    n_checks++; if (input_port !== exp_q[0]) begin n_fail++; $display("FAIL irq_pop: got %h expected %h", input_port, exp_q[0]); end
    tick();
    in_read = 1'b0;
    n_checks++; if (in_valid !== 1'b0) begin n_fail++; $display("FAIL irq_empty: got %b expected 0", in_valid); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (interrupt_signal !== 1'b0) begin n_fail++; $display("FAIL irq_no_retrig%0d: got %b expected 0", k, interrupt_signal); end
    end
  endtask

  task automatic test_retrigger();
    bit exp_pat [4];
    exp_pat[0] = 1'b0; exp_pat[1] = 1'b1; exp_pat[2] = 1'b1; exp_pat[3] = 1'b0;
    dev_valid = 1'b1; dev_data = 16'h5A01;
    tick();
    dev_data = 16'h5A02;
    tick();
    dev_valid = 1'b0;
    n_checks++; if (interrupt_signal !== 1'b1) begin n_fail++; $display("FAIL retrig_first: got %b expected 1", interrupt_signal); end
    tick(); tick(); tick();
    n_checks++; if (interrupt_signal !== 1'b0) begin n_fail++; $display("FAIL retrig_service: got %b expected 0", interrupt_signal); end
    in_read = 1'b1;
    n_checks++; if (input_port !== exp_q[0]) begin n_fail++; $display("FAIL retrig_pop: got %h expected %h", input_port, exp_q[0]); end
    for (int k = 0; k < 4; k++) begin
      tick();
      in_read = 1'b0;
      n_checks++; if (interrupt_signal !== exp_pat[k]) begin n_fail++; $display("FAIL retrig_pat%0d: got %b expected %b", k, interrupt_signal, exp_pat[k]); end
    end
    in_read = 1'b1;
    n_checks++; if (input_port !== exp_q[0]) begin n_fail++; $display("FAIL retrig_pop2: got %h expected %h", input_port, exp_q[0]); end
    tick();
    in_read = 1'b0;
    tick(); tick();
    n_checks++; if (interrupt_signal !== 1'b0) begin n_fail++; $display("FAIL retrig_idle: got %b expected 0", interrupt_signal); end
    int_enable = 1'b0;
  endtask

  task automatic test_underflow_simul();
    in_read = 1'b1; dev_valid = 1'b1; dev_data = 16'h0F0F;
    tick();
    in_read = 1'b0; dev_valid = 1'b0;
    n_checks++; if (underflow !== exp_uf) begin n_fail++; $display("FAIL uf_pulse: got %b expected %b", underflow, exp_uf); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL uf_count: got %0d expected 1", count); end
    n_checks++; if (input_port !== 16'h0F0F) begin n_fail++; $display("FAIL uf_port: got %h expected 0f0f", input_port); end
    tick();
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL uf_clear: got %b expected 0", underflow); end
    dev_valid = 1'b1; dev_data = 16'h1234;
    tick();
    dev_data = 16'h5678; in_read = 1'b1;
    n_checks++; if (input_port !== exp_q[0]) begin n_fail++; $display("FAIL simul_pop: got %h expected %h", input_port, exp_q[0]); end
    tick();
    dev_valid = 1'b0; in_read = 1'b0;
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL simul_count: got %0d expected 2", count); end
    n_checks++; if (input_port !== exp_q[0]) begin n_fail++; $display("FAIL simul_head: got %h expected %h", input_port, exp_q[0]); end
    in_read = 1'b1;
    while (exp_q.size() != 0) begin
      n_checks++; if (input_port !== exp_q[0]) begin n_fail++; $display("FAIL simul_drain: got %h expected %h", input_port, exp_q[0]); end
      tick();
    end
    in_read = 1'b0;
  endtask

  task automatic test_enable_abort();
    int_enable = 1'b1; dev_valid = 1'b1; dev_data = 16'hE001;
    tick();
    dev_valid = 1'b0;
    tick();
    n_checks++; if (interrupt_signal !== 1'b1) begin n_fail++; $display("FAIL en_pulse: got %b expected 1", interrupt_signal); end
    int_enable = 1'b0;
    tick();
    n_checks++; if (interrupt_signal !== 1'b0) begin n_fail++; $display("FAIL en_drop: got %b expected 0", interrupt_signal); end
    in_read = 1'b1;
    n_checks++; if (input_port !== exp_q[0]) begin n_fail++; $display("FAIL en_pop: got %h expected %h", input_port, exp_q[0]); end
    tick();
    in_read = 1'b0;
    int_enable = 1'b1; dev_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dev_data = 16'hC001 + 16'(i);
      tick();
    end
    dev_valid = 1'b0;
    n_checks++; if (interrupt_signal !== 1'b1 || count !== 3'd3) begin n_fail++; $display("FAIL rst_pre: got int=%b count=%0d expected int=1 count=3", interrupt_signal, count); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (interrupt_signal !== 1'b0) begin n_fail++; $display("FAIL rst_abort_int: got %b expected 0", interrupt_signal); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_abort_count: got %0d expected 0", count); end
    n_checks++; if (in_valid !== 1'b0) begin n_fail++; $display("FAIL rst_abort_valid: got %b expected 0", in_valid); end
    int_enable = 1'b0;
    exp_q.delete();
    @(negedge clk); rst = 1'b1;
    tick();
    n_checks++; if (count !== 3'd0 || interrupt_signal !== 1'b0) begin n_fail++; $display("FAIL rst_after: got count=%0d int=%b expected 0 0", count, interrupt_signal); end
  endtask

  initial begin
    test_reset();
    test_order();
    test_full_wrap();
    test_interrupt();
    test_retrigger();
    test_underflow_simul();
    test_enable_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/input_port_controller.md
# input_port_controller

Producer side of the processor's input port and interrupt line. Accepts 16-bit words from an external device over a valid/ready handshake, buffers them in a small FIFO, and presents the head word on `input_port` for the processor's IN instruction, which pops it via a one-cycle read strobe. A small state machine raises `interrupt_signal` toward the processor when buffered data is waiting and holds off re-triggering until the processor has consumed a word.

## Interface
- `DATA_WIDTH`, 16, word width; matches the processor port width.
- `DEPTH`, 4, FIFO entries; power of two, at least 2.
- `INT_HOLD`, 2, cycles `interrupt_signal` stays high per request; at least 1.

- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `dev_valid`  input  1  device offers `dev_data`.
- `dev_data`  input  DATA_WIDTH  device word.
- `dev_ready`  output  1  FIFO can accept; equals not-full.
- `in_read`  input  1  processor IN strobe; pops the head word.
- `int_enable`  input  1  gates interrupt generation.
- `input_port`  output  DATA_WIDTH  head word; 0 when empty.
- `in_valid`  output  1  FIFO non-empty.
- `interrupt_signal`  output  1  interrupt request to the processor.
- `count`  output  $clog2(DEPTH)+1  current occupancy.
- `underflow`  output  1  one-cycle pulse when `in_read` arrives while empty.

## Operation
- FIFO storage: circular buffer with `DEPTH` entries, a write pointer, a read pointer, and an occupancy counter. Pointers wrap modulo `DEPTH`.
- Push: when `dev_valid && dev_ready` at a clock edge, write `dev_data` at the write pointer, advance the write pointer, and increment `count`.
- Pop: when `in_read && in_valid` at a clock edge, advance the read pointer and decrement `count`.
- Simultaneous push and pop (not full, not empty): both happen and `count` is unchanged.
- When full, `dev_ready` is 0, so no push is accepted even if a pop happens in the same cycle.
- When empty and `in_read` is high:
  - no pop occurs and `underflow` is 1 for the next cycle;
  - a simultaneous push is still accepted.
- `input_port` is a combinational read of the head entry, forced to 0 when `count`==0. `in_valid` is `count`!=0.
- Interrupt FSM has three states: IDLE, PULSE, SERVICE.
  - IDLE -> PULSE when `int_enable && in_valid`; the hold counter loads `INT_HOLD-1`.
  - PULSE: `interrupt_signal`=1. The counter decrements each cycle; at 0, go to SERVICE. If `int_enable` drops, go to IDLE immediately.
  - SERVICE: `interrupt_signal`=0. Leave for IDLE on the first accepted pop. If `int_enable` drops, go to IDLE.
  - A pop that happens during PULSE is recorded, so SERVICE exits on its first cycle.
- After returning to IDLE, if data is still buffered, the FSM re-enters PULSE on the following edge. There is therefore at least one low cycle between requests.
- `interrupt_signal` is a registered output, equal to state==PULSE.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - pointers and `count` to 0, FSM to IDLE;
  - `interrupt_signal`=0, `underflow`=0, `in_valid`=0, `input_port`=0, `dev_ready`=1.
- FIFO contents are not reset; they are never visible while `count`==0.
- Reset asserted mid-request drops `interrupt_signal` immediately and discards buffered words.
- Push latency: a word accepted at edge N appears on `input_port` (if the FIFO was empty) and raises `in_valid` right after edge N.
- Interrupt latency: with `int_enable`=1 and a first word accepted at edge N, `interrupt_signal` is high after edges N+1 through N+INT_HOLD, then low in SERVICE.
- A pop at edge M shows the next head word, or 0 if the FIFO is now empty, right after M.
- `dev_ready` is combinational from `count`.

## Test plan
- Reset and ordering:
  - Stimulus: reset, then push 0x1111, 0x2222, 0x3333 on consecutive cycles, `int_enable`=0.
  - Required: `count`=3, `input_port`=0x1111. Three `in_read` pulses yield 0x1111, 0x2222, 0x3333, then 0x0000 with `in_valid`=0. `interrupt_signal` never asserts.
- Full and wrap-around:
  - Stimulus: push 5 words with `dev_valid` held high and DEPTH=4.
  - Required: `dev_ready`=0 after the fourth word and the fifth word is held. After one pop, the fifth word is accepted at the next edge. Pointers wrap, and 6 further push/pop pairs preserve FIFO order.
- Interrupt cycle:
  - Stimulus: `int_enable`=1, INT_HOLD=2, push 0xABCD at edge N.
  - Required: `interrupt_signal`=1 for exactly 2 cycles starting after N+1. The FSM holds SERVICE until `in_read`, then returns to IDLE. With no data left, there is no re-trigger.
- Re-trigger:
  - Stimulus: push two words, then pop one during SERVICE.
  - Required: IDLE for one cycle, then a second 2-cycle pulse.
- Underflow and simultaneous events:
  - Stimulus: `in_read` while empty, together with a push of 0x0F0F.
  - Required: `underflow` pulses for 1 cycle, `count`=1, `input_port`=0x0F0F.
  - Stimulus: push and pop together at `count`=2.
  - Required: `count` stays 2.
- Enable and reset abort:
  - Stimulus: drop `int_enable` during PULSE.
  - Required: `interrupt_signal`=0 on the next cycle.
  - Stimulus: assert `rst` mid-PULSE with 3 words buffered.
  - Required: `interrupt_signal`, `count`, and `in_valid` go to 0 immediately, without waiting for a clock edge.
